pop_threshold_detector: RTL and testbench
=========================================

# pop_threshold_detector

Parametrised, streaming successor to the three-input pair/triple detector. Each input beat is an NBITS-wide vector. The block counts its set bits and flags a hit when the count is greater than or equal to a runtime threshold. It also raises a sticky alarm after RUN_LEN consecutive hits. It sits between a valid/ready producer and consumer as a one-stage registered pipeline; NBITS=3 with thresh=2 reproduces the original pair/triple function.

## Interface

- NBITS, 8, width of the input vector (≥1)
- RUN_LEN, 3, number of consecutive accepted hits that sets the alarm (≥1)
- CW, $clog2(NBITS+1), derived width of the count and threshold; not overridden by users

- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset; clears all state immediately while low
- in_val  input  1  input beat valid
- in_rdy  output  1  block can accept a beat
- in_data  input  NBITS  vector to evaluate
- thresh  input  CW  hit threshold, sampled together with in_data on accept
- out_val  output  1  output beat valid
- out_rdy  input  1  consumer accepts the output beat
- out_count  output  CW  popcount of the accepted vector
- out_hit  output  1  1 iff out_count ≥ sampled thresh
- alarm  output  1  sticky alarm flag
- alarm_clr  input  1  synchronous clear of the alarm and the run counter

## Operation

- Accept condition: in_val && in_rdy. Output handoff: out_val && out_rdy.
- in_rdy = !out_val || out_rdy. This is combinational and gives full throughput of one beat per cycle with back-to-back accepts.
- On accept, the block registers:
  - out_count = number of 1 bits in in_data, range 0..NBITS, exact in CW bits with no overflow.
  - out_hit = (popcount ≥ thresh), unsigned compare.
  - out_val = 1.
- Output hold: if out_val && !out_rdy, then out_count, out_hit and out_val hold. in_rdy is 0 during this time.
- When a handoff occurs with no new accept, out_val goes to 0. out_count and out_hit keep their last values; they are don't-care while out_val=0.
- Threshold edge cases:
  - thresh=0: every beat is a hit.
  - thresh>NBITS: no beat is ever a hit.
- Run counter: width $clog2(RUN_LEN+1). It is internal and updated only on accept.
  - An accepted hit increments it, saturating at RUN_LEN.
  - An accepted miss clears it to 0.
- State machine, derived from the run counter and alarm:
  - IDLE: run=0, alarm=0.
  - ARMING: 0<run<RUN_LEN, alarm=0.
  - ALARM: alarm=1.
- Transitions:
  - IDLE→ARMING on an accepted hit; if RUN_LEN=1, IDLE→ALARM directly.
  - ARMING→ALARM on the accepted hit that makes run=RUN_LEN.
  - ARMING→IDLE on an accepted miss.
  - ALARM stays in ALARM regardless of hits and misses; only the run counter tracks them.
  - ALARM→IDLE only on alarm_clr or reset.
- alarm_clr has priority. In a cycle with alarm_clr=1:
  - alarm becomes 0 and the run counter becomes 0.
  - A beat accepted in the same cycle still produces its output normally.
  - That beat's hit/miss is not counted toward the run.
- alarm_clr has no effect on the datapath or the handshake.

## Timing

- Latency: 1 cycle. A beat accepted at edge k is visible on the outputs after edge k, and can be handed off at edge k+1 at the earliest.
- alarm is registered. It rises after the same edge that registers the completing hit, in the same cycle that beat's out_val/out_hit become visible.
- While reset=0:
  - out_val=0, out_count=0, out_hit=0, alarm=0, run=0.
  - in_rdy=1, which follows from out_val=0.
- Reset deassertion is not synchronised inside the block; the system provides a synchronous release.
- Reset asserted mid-operation:
  - A pending output beat is dropped.
  - The alarm and run history are lost.
  - No partial state survives.
- Simultaneous handoff and accept: the old beat leaves and the new beat is registered at the same edge, with no bubble.
- The in_data/thresh values of non-accepted cycles are ignored. The datapath and run state change only on accept, reset, or alarm_clr.

## Test plan

- Legacy equivalence: NBITS=3. Apply all 8 vectors with thresh=2 and out_rdy=1 → out_hit is 1 exactly for 011, 101, 110, 111. out_count equals the popcount, one cycle after each accept.
- Threshold bounds: NBITS=8, in_data=8'hFF. thresh=0 → hit. thresh=8 → hit. thresh=9 → miss, with out_count=8. in_data=8'h00 with thresh=0 → hit, out_count=0.
- Backpressure: hold out_rdy=0 for 3 cycles after an accept of 8'h0F → out_val=1 and out_count=4 stay stable, and in_rdy=0. Raise out_rdy with in_val=1 → handoff and new accept in the same cycle.
- Alarm run: RUN_LEN=3, thresh=4. Send hit, hit, miss, hit, hit, hit → alarm rises with the 6th beat's output, not earlier. Further misses leave alarm=1.
- Clear priority: while alarm=1, assert alarm_clr in the same cycle as an accepted hit → alarm=0 next cycle. Three more hits are needed to re-alarm, not two.
- Async reset: drop reset between edges while out_val=1 and alarm=1 → out_val, out_count, out_hit and alarm go to 0 immediately, before the next edge. After release, in_rdy=1.

Source files
------------

// File: rtl/pop_threshold_detector_if.sv
// Stream bundle for pop_threshold_detector: input beat channel (vector +
// threshold) and registered output channel (popcount + hit flag).
interface pop_threshold_detector_if #(
    parameter int NBITS = 8,
    parameter int CW    = $clog2(NBITS + 1)
);
    // Handshake: a beat moves on a channel at a rising clock edge where both
    // its valid and its ready are 1. A producer holding valid=1 keeps its data
    // stable until that edge; ready may depend combinationally on the far side.
    logic             in_val;
    logic             in_rdy;
    logic [NBITS-1:0] in_data;
    logic [CW-1:0]    thresh;
    logic             out_val;
    logic             out_rdy;
    logic [CW-1:0]    out_count;
    logic             out_hit;

    // Producer of input beats and consumer of results.
    modport master (
        output in_val, in_data, thresh, out_rdy,
        input  in_rdy, out_val, out_count, out_hit
    );

    // The detector itself.
    modport slave (
        input  in_val, in_data, thresh, out_rdy,
        output in_rdy, out_val, out_count, out_hit
    );
endinterface

// File: rtl/pop_threshold_detector.sv
// Streaming popcount threshold detector. Each accepted beat is reduced to its
// set-bit count, compared against the threshold sampled with it, and the
// result is presented one cycle later. A run of RUN_LEN consecutive accepted
// hits sets a sticky alarm that only alarm_clr or reset can clear.
module pop_threshold_detector #(
    parameter int NBITS   = 8,
    parameter int RUN_LEN = 3,
    localparam int CW     = $clog2(NBITS + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    pop_threshold_detector_if.slave   bus,
    input  logic                      alarm_clr,
    output logic                      alarm,
    output logic [1:0]                dbg_state
);
    localparam int RW = $clog2(RUN_LEN + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMING = 2'd1,
        ALARM  = 2'd2
    } state_t;

    state_t           state;
    logic [RW-1:0]    run;
    logic             alarm_q;

    logic             out_val_q;
    logic [CW-1:0]    out_count_q;
    logic             out_hit_q;

    logic [CW-1:0]    pop;
    logic             hit_now;
    logic             accept;
    logic [RW-1:0]    run_next;

    // Ready whenever the output slot is empty or is being drained this cycle.
    assign bus.in_rdy = !out_val_q || bus.out_rdy;
    assign accept     = bus.in_val && bus.in_rdy;

    // Count the set bits of the incoming vector; CW bits hold 0..NBITS exactly.
    always_comb begin
        pop = '0;
        for (int i = 0; i < NBITS; i++) begin
            pop = pop + CW'(bus.in_data[i]);
        end
    end

    // Unsigned compare; thresh above NBITS can never be reached.
    assign hit_now = (pop >= bus.thresh);

    // Run counter saturates at RUN_LEN so it never wraps while alarmed.
    assign run_next = !hit_now            ? '0 :
                      (run == RW'(RUN_LEN)) ? run : run + RW'(1);

    // Output register: load on accept, drop valid on a bare handoff, else hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_val_q   <= 1'b0;
            out_count_q <= '0;
            out_hit_q   <= 1'b0;
        end else if (accept) begin
            out_val_q   <= 1'b1;
            out_count_q <= pop;
            out_hit_q   <= hit_now;
        end else if (bus.out_rdy) begin
            out_val_q   <= 1'b0;
        end
    end

    // Alarm FSM with its run counter; alarm_clr wins over a same-cycle accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            run     <= '0;
            alarm_q <= 1'b0;
        end else if (alarm_clr) begin
            state   <= IDLE;
            run     <= '0;
            alarm_q <= 1'b0;
        end else if (accept) begin
            run <= run_next;
            case (state)
                IDLE, ARMING: begin
                    if (run_next == RW'(RUN_LEN)) begin
                        state   <= ALARM;
                        alarm_q <= 1'b1;
                    end else if (hit_now) begin
                        state   <= ARMING;
                    end else begin
                        state   <= IDLE;
                    end
                end
                ALARM: begin
                    state   <= ALARM;
                    alarm_q <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    run     <= '0;
                    alarm_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_val   = out_val_q;
    assign bus.out_count = out_count_q;
    assign bus.out_hit   = out_hit_q;
    assign alarm         = alarm_q;
    assign dbg_state     = state;
endmodule

// File: tb/tb_pop_threshold_detector.sv
// Bench for pop_threshold_detector: directed scenarios then random traffic on
// an NBITS=8 instance, plus the legacy 3-input behaviour on an NBITS=3 one.
module tb_pop_threshold_detector;
    localparam int NBITS   = 8;
    localparam int RUN_LEN = 3;
    localparam int CW      = $clog2(NBITS + 1);

    logic clk;
    logic rst_n;
    logic alarm_clr;
    logic alarm;
    logic [1:0] dbg_state;
    logic alarm_clr3;
    logic alarm3;
    logic [1:0] dbg_state3;

    int total;
    int bad;

    // Reference model state.
    logic [CW:0] exp_q[$];   // {hit, count} of the beat sitting in the output slot
    int          streak;     // consecutive accepted hits since last clear
    bit          m_alarm;

    pop_threshold_detector_if #(.NBITS(NBITS)) bus ();
    pop_threshold_detector_if #(.NBITS(3))     bus3 ();

    pop_threshold_detector #(.NBITS(NBITS), .RUN_LEN(RUN_LEN)) u_dut (
        .clk       (clk),
        .reset     (rst_n),
        .bus       (bus.slave),
        .alarm_clr (alarm_clr),
        .alarm     (alarm),
        .dbg_state (dbg_state)
    );

    pop_threshold_detector #(.NBITS(3), .RUN_LEN(3)) u_dut3 (
        .clk       (clk),
        .reset     (rst_n),
        .bus       (bus3.slave),
        .alarm_clr (alarm_clr3),
        .alarm     (alarm3),
        .dbg_state (dbg_state3)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        streak  = 0;
        m_alarm = 1'b0;
    endtask

    // Outputs the model predicts right now.
    task automatic check_outputs(input string tag);
        check({tag, ".out_val"}, 32'(bus.out_val), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check({tag, ".out_count"}, 32'(bus.out_count), 32'(exp_q[0][CW-1:0]));
            check({tag, ".out_hit"},   32'(bus.out_hit),   32'(exp_q[0][CW]));
        end
        check({tag, ".alarm"}, 32'(alarm), 32'(m_alarm));
        check({tag, ".state"}, 32'(dbg_state),
              m_alarm ? 32'd2 : (streak > 0 ? 32'd1 : 32'd0));
    endtask

    // One clock cycle of traffic on the 8-bit instance.
    task automatic step(input string tag, input bit v, input logic [NBITS-1:0] d,
                        input logic [CW-1:0] t, input bit r, input bit c);
        bit exp_rdy;
        bit acc;
        bit hit;
        int cnt;
        @(negedge clk);
        bus.in_val  = v;
        bus.in_data = d;
        bus.thresh  = t;
        bus.out_rdy = r;
        alarm_clr   = c;
        #1;
        exp_rdy = (exp_q.size() == 0) || r;
        check({tag, ".in_rdy"}, 32'(bus.in_rdy), 32'(exp_rdy));
        acc = v && exp_rdy;
        cnt = $countones(d);
        hit = (cnt >= int'(t));
        if (exp_q.size() != 0 && r) void'(exp_q.pop_front());
        if (acc) exp_q.push_back({hit, CW'(cnt)});
        if (c) begin
            streak  = 0;
            m_alarm = 1'b0;
        end else if (acc) begin
            streak = hit ? streak + 1 : 0;
            if (streak >= RUN_LEN) m_alarm = 1'b1;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_reset();
        rst_n        = 1'b0;
        alarm_clr    = 1'b0;
        bus.in_val   = 1'b0;
        bus.in_data  = '0;
        bus.thresh   = '0;
        bus.out_rdy  = 1'b0;
        alarm_clr3   = 1'b0;
        bus3.in_val  = 1'b0;
        bus3.in_data = '0;
        bus3.thresh  = '0;
        bus3.out_rdy = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst.in_rdy", 32'(bus.in_rdy), 32'd1);
        check("rst.count", 32'(bus.out_count), 32'd0);
        check("rst.hit", 32'(bus.out_hit), 32'd0);
        check_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Legacy 3-input pair/triple behaviour
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vec;
            vec = 3'(v);
            @(negedge clk);
            bus3.in_val  = 1'b1;
            bus3.in_data = vec;
            bus3.thresh  = 2'd2;
            bus3.out_rdy = 1'b1;
            @(posedge clk);
            #1;
            check("legacy.val", 32'(bus3.out_val), 32'd1);
            check("legacy.count", 32'(bus3.out_count), 32'($countones(vec)));
            check("legacy.hit", 32'(bus3.out_hit), 32'(v == 3 || v == 5 || v == 6 || v == 7));
        end
        // Hits 101,110,111 are the last three beats in a row.
        check("legacy.alarm", 32'(alarm3), 32'd1);
        @(negedge clk);
        bus3.in_val = 1'b0;

        // Threshold bounds
        step("th0", 1'b1, 8'hFF, 4'd0, 1'b1, 1'b0);
        step("th8", 1'b1, 8'hFF, 4'd8, 1'b1, 1'b0);
        step("th9", 1'b1, 8'hFF, 4'd9, 1'b1, 1'b0);
        step("zero", 1'b1, 8'h00, 4'd0, 1'b1, 1'b0);
        step("miss", 1'b1, 8'h01, 4'd2, 1'b1, 1'b0);
        step("drain", 1'b0, 8'h00, 4'd0, 1'b1, 1'b0);

        // Backpressure: offered beats during the stall must be ignored
        step("bp.acc", 1'b1, 8'h0F, 4'd4, 1'b0, 1'b0);
        step("bp.h1", 1'b0, 8'hFF, 4'd0, 1'b0, 1'b0);
        step("bp.h2", 1'b1, 8'hFF, 4'd0, 1'b0, 1'b0);
        step("bp.h3", 1'b1, 8'h00, 4'd9, 1'b0, 1'b0);
        step("bp.swap", 1'b1, 8'h03, 4'd1, 1'b1, 1'b0);
        step("bp.drain", 1'b0, 8'h00, 4'd0, 1'b1, 1'b0);

        // Alarm run: hit, hit, miss, hit, hit, hit, then misses
        step("clr0", 1'b0, 8'h00, 4'd0, 1'b1, 1'b1);
        step("run1", 1'b1, 8'h0F, 4'd4, 1'b1, 1'b0);
        step("run2", 1'b1, 8'hF0, 4'd4, 1'b1, 1'b0);
        step("run3", 1'b1, 8'h07, 4'd4, 1'b1, 1'b0);
        step("run4", 1'b1, 8'h1F, 4'd4, 1'b1, 1'b0);
        step("run5", 1'b1, 8'hFF, 4'd4, 1'b1, 1'b0);
        step("run6", 1'b1, 8'h3C, 4'd4, 1'b1, 1'b0);
        step("run7", 1'b1, 8'h00, 4'd4, 1'b1, 1'b0);
        step("run8", 1'b1, 8'h01, 4'd4, 1'b1, 1'b0);

        // Clear priority over a same-cycle hit, then three hits to re-alarm
        step("cp.clr", 1'b1, 8'hFF, 4'd4, 1'b1, 1'b1);
        step("cp.h1", 1'b1, 8'h0F, 4'd4, 1'b1, 1'b0);
        step("cp.h2", 1'b1, 8'h0F, 4'd4, 1'b1, 1'b0);
        step("cp.h3", 1'b1, 8'h0F, 4'd4, 1'b1, 1'b0);

        // Async reset between edges with a pending beat and alarm set
        step("ar.load", 1'b1, 8'h0F, 4'd4, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("ar.out_val", 32'(bus.out_val), 32'd0);
        check("ar.out_count", 32'(bus.out_count), 32'd0);
        check("ar.out_hit", 32'(bus.out_hit), 32'd0);
        check("ar.alarm", 32'(alarm), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ar.in_rdy", 32'(bus.in_rdy), 32'd1);
        check_outputs("ar.rel");

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step("rnd",
                 bit'($urandom_range(0, 3) != 0),
                 NBITS'($urandom),
                 CW'($urandom_range(0, 10)),
                 bit'($urandom_range(0, 2) != 0),
                 bit'($urandom_range(0, 15) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
